cache_ctrl_nway: RTL and testbench

Parametrised control FSM for an N-way, write-back, write-allocate set-associative cache. It sits between the CPU request port and the cache arbiter (`ca_resp` handshake) and drives per-way one-hot load/valid/dirty strobes into the tag and data arrays. It extends the 2-way controller in four ways:
- a configurable way count;
- victim latching, with preference for invalid ways;
- write-hit byte merging with dirty marking;
- an optional memory-handshake timeout.

---
 rtl/cache_ctrl_nway.sv | 179 +++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - N-way write-back/write-allocate cache control FSM.
// Optional memory-wait timeout enabled by defining CACHE_CTRL_TIMEOUT_EN.
module cache_ctrl_nway #(
  parameter int WAYS = 2,
  parameter int TIMEOUT = 255,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [WAYS-1:0]  hit_way,
  input  logic [WAYS-1:0]  is_valid,
  input  logic [WAYS-1:0]  is_dirty,
  input  logic [WAY_W-1:0] victim,
  input  logic             ca_resp,
  output logic             cpu_mem_valid,
  output logic             lru_load,
  output logic [WAY_W-1:0] lru_way,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WAYS-1:0]  load_data_line,
  output logic [WAYS-1:0]  load_data_bytes,
  output logic [WAYS-1:0]  load_tag,
  output logic             data_in_select,
  output logic [WAYS-1:0]  set_valid,
  output logic [WAYS-1:0]  write_valid,
  output logic [WAYS-1:0]  set_dirty,
  output logic [WAYS-1:0]  write_dirty,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    CHECK          = 3'd1,
    WB_WAIT_RESP   = 3'd2,
    WB_WAIT_DONE   = 3'd3,
    FILL_WAIT_RESP = 3'd4,
    FILL_WAIT_DONE = 3'd5,
    ERROR          = 3'd6
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             op_wr;
  logic [WAY_W-1:0] vic_q;
  logic [WAY_W-1:0] vic_sel;
  logic [WAY_W-1:0] hit_idx;
  logic [WAYS-1:0]  hv;
  logic [WAYS-1:0]  vic_oh;
  logic             multi_hit;
  logic             any_hit;
  logic             req;

  assign req    = cpu_read | cpu_write;
  assign vic_oh = WAYS'(1) << vic_q;

  always_comb begin
    hv        = hit_way & is_valid;
    multi_hit = |(hv & (hv - WAYS'(1)));
    any_hit   = |hv;
    hit_idx   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hv[i]) hit_idx = WAY_W'(i);
    end
    // Descending scan so the lowest-index invalid way wins over the LRU pick.
    vic_sel = victim;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!is_valid[i]) vic_sel = WAY_W'(i);
    end
  end

`ifdef CACHE_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             wait_state;

  assign wait_state = (state == WB_WAIT_RESP) || (state == WB_WAIT_DONE) ||
                      (state == FILL_WAIT_RESP) || (state == FILL_WAIT_DONE);
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:           if (req) next_state = CHECK;
      CHECK: begin
        if (multi_hit)                                next_state = ERROR;
        else if (any_hit)                             next_state = IDLE;
        else if (is_valid[vic_sel] && is_dirty[vic_sel]) next_state = WB_WAIT_RESP;
        else                                          next_state = FILL_WAIT_RESP;
      end
      WB_WAIT_RESP:   if (ca_resp)  next_state = WB_WAIT_DONE;
      WB_WAIT_DONE:   if (!ca_resp) next_state = FILL_WAIT_RESP;
      FILL_WAIT_RESP: if (ca_resp)  next_state = FILL_WAIT_DONE;
      FILL_WAIT_DONE: if (!ca_resp) next_state = CHECK;
      ERROR:          next_state = IDLE;
      default:        next_state = ERROR;
    endcase
`ifdef CACHE_CTRL_TIMEOUT_EN
    if (wait_state && (next_state == state) && (tmo_cnt == TMO_W'(TIMEOUT - 1)))
      next_state = ERROR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_wr <= 1'b0;
      vic_q <= '0;
`ifdef CACHE_CTRL_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      state <= next_state;
      if (state == IDLE && req) op_wr <= cpu_write;
      if (state == CHECK && !multi_hit && !any_hit) vic_q <= vic_sel;
`ifdef CACHE_CTRL_TIMEOUT_EN
      if (next_state != state) tmo_cnt <= '0;
      else if (wait_state)     tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
    end
  end

  // Outputs decode the current state and the live array status so a hit
  // completes in the CHECK cycle itself.
  always_comb begin
    cpu_mem_valid   = 1'b0;
    lru_load        = 1'b0;
    lru_way         = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    load_data_line  = '0;
    load_data_bytes = '0;
    load_tag        = '0;
    data_in_select  = 1'b0;
    set_valid       = '0;
    write_valid     = '0;
    set_dirty       = '0;
    write_dirty     = '0;
    error           = 1'b0;
    if (!rst) begin
      case (state)
        CHECK: begin
          if (!multi_hit && any_hit) begin
            cpu_mem_valid = 1'b1;
            lru_load      = 1'b1;
            lru_way       = hit_idx;
            if (op_wr) begin
              load_data_bytes = hv;
              set_dirty       = hv;
              write_dirty     = hv;
            end
          end
        end
        WB_WAIT_RESP, WB_WAIT_DONE: mem_write = 1'b1;
        FILL_WAIT_RESP:             mem_read  = 1'b1;
        FILL_WAIT_DONE: begin
          mem_read = 1'b1;
          if (!ca_resp) begin
            load_data_line = vic_oh;
            load_tag       = vic_oh;
            data_in_select = 1'b1;
            set_valid      = vic_oh;
            write_valid    = vic_oh;
            write_dirty    = vic_oh;
          end
        end
        ERROR: begin
          error         = 1'b1;
          cpu_mem_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - scoreboard bench for cache_ctrl_nway (WAYS=4).
module tb_cache_ctrl_nway;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_read, cpu_write;
  logic [3:0] hit_way, is_valid, is_dirty;
  logic [1:0] victim;
  logic       ca_resp;
  logic       cpu_mem_valid, lru_load, mem_read, mem_write, data_in_select, error;
  logic [1:0] lru_way;
  logic [3:0] load_data_line, load_data_bytes, load_tag;
  logic [3:0] set_valid, write_valid, set_dirty, write_dirty;

  cache_ctrl_nway #(.WAYS(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .hit_way(hit_way), .is_valid(is_valid), .is_dirty(is_dirty), .victim(victim),
    .ca_resp(ca_resp), .cpu_mem_valid(cpu_mem_valid), .lru_load(lru_load),
    .lru_way(lru_way), .mem_read(mem_read), .mem_write(mem_write),
    .load_data_line(load_data_line), .load_data_bytes(load_data_bytes),
    .load_tag(load_tag), .data_in_select(data_in_select), .set_valid(set_valid),
    .write_valid(write_valid), .set_dirty(set_dirty), .write_dirty(write_dirty),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Tag/valid/dirty arrays of the indexed set, written by the DUT strobes.
  logic [3:0] env_tag [4];
  logic [3:0] env_valid, env_dirty;
  logic [3:0] cur_tag;
  logic       force_multi;
  logic [3:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < 4; i++) match[i] = (env_tag[i] == cur_tag);
  end
  assign hit_way  = force_multi ? 4'hF : match;
  assign is_valid = env_valid;
  assign is_dirty = env_dirty;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (write_valid[i]) env_valid[i] <= set_valid[i];
        if (write_dirty[i]) env_dirty[i] <= set_dirty[i];
        if (load_tag[i])    env_tag[i]   <= cur_tag;
      end
    end
  end

  // Reference model of the set, updated at issue time from the cache rules.
  logic [3:0] m_tag [4];
  logic [3:0] m_valid, m_dirty;

  typedef struct { bit err; bit miss; bit wb; bit wr; int way; } exp_t;
  exp_t sb [$];

  bit mon_en = 1'b0;
  bit arb_en = 1'b0;

  initial begin
    int d, h;
    forever begin
      @(posedge clk); #1;
      if (arb_en && !rst && (mem_read || mem_write)) begin
        d = $urandom_range(0, 2);
        repeat (d) begin @(posedge clk); #1; end
        ca_resp = 1'b1;
        h = $urandom_range(1, 3);
        repeat (h) begin @(posedge clk); #1; end
        ca_resp = 1'b0;
      end
    end
  end

  initial begin
    bit a_wr, a_rd;
    logic [3:0] a_bytes, a_fill, oh;
    exp_t e;
    a_wr = 0; a_rd = 0; a_bytes = 0; a_fill = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_wr = 0; a_rd = 0; a_bytes = 0; a_fill = 0;
      end else if (mon_en) begin
        a_wr = a_wr | mem_write;
        a_rd = a_rd | mem_read;
        a_bytes = a_bytes | load_data_bytes;
        a_fill = a_fill | load_data_line;
        if (lru_load && !cpu_mem_valid) chk("lru_load_alone", 32'(lru_load), 32'(0));
        if (load_data_bytes != 0) begin
          chk("merge_set_dirty", 32'(set_dirty), 32'(load_data_bytes));
          chk("merge_write_dirty", 32'(write_dirty), 32'(load_data_bytes));
          chk("merge_dsel", 32'(data_in_select), 32'(0));
        end
        if (load_data_line != 0) begin
          chk("fill_onehot", 32'($onehot(load_data_line)), 32'(1));
          chk("fill_tag", 32'(load_tag), 32'(load_data_line));
          chk("fill_set_valid", 32'(set_valid), 32'(load_data_line));
          chk("fill_write_valid", 32'(write_valid), 32'(load_data_line));
          chk("fill_set_dirty", 32'(set_dirty), 32'(0));
          chk("fill_write_dirty", 32'(write_dirty), 32'(load_data_line));
          chk("fill_dsel", 32'(data_in_select), 32'(1));
        end
        if (cpu_mem_valid) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_done", 32'(1), 32'(0));
          end else begin
            e = sb.pop_front();
            oh = 4'(1) << e.way;
            chk("error", 32'(error), 32'(e.err));
            chk("lru_load", 32'(lru_load), 32'(!e.err));
            if (!e.err) chk("lru_way", 32'(lru_way), 32'(e.way));
            chk("saw_mem_write", 32'(a_wr), 32'(e.wb));
            chk("saw_mem_read", 32'(a_rd), 32'(e.miss));
            chk("bytes_mask", 32'(a_bytes), 32'((e.wr && !e.err) ? oh : 4'h0));
            chk("fill_mask", 32'(a_fill), 32'(e.miss ? oh : 4'h0));
          end
          a_wr = 0; a_rd = 0; a_bytes = 0; a_fill = 0;
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [3:0] tag, input logic [1:0] vic, input bit fm);
    exp_t e;
    logic [3:0] mt, hv;
    int w, k;
    bit seen;
    mt = '0;
    for (int i = 0; i < 4; i++) mt[i] = (m_tag[i] == tag);
    hv = (fm ? 4'hF : mt) & m_valid;
    e = '{err: 0, miss: 0, wb: 0, wr: wr, way: 0};
    w = 0;
    if ($countones(hv) > 1) begin
      e.err = 1;
    end else if (hv != 0) begin
      for (int i = 0; i < 4; i++) if (hv[i]) w = i;
    end else begin
      e.miss = 1;
      w = int'(vic);
      for (int i = 3; i >= 0; i--) if (!m_valid[i]) w = i;
      e.wb = m_valid[w] && m_dirty[w];
    end
    e.way = w;
    if (!e.err) begin
      if (e.miss) begin
        m_tag[w] = tag; m_valid[w] = 1'b1; m_dirty[w] = wr;
      end else if (wr) begin
        m_dirty[w] = 1'b1;
      end
    end
    sb.push_back(e);
    @(posedge clk); #1;
    cpu_write = wr;
    cpu_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cur_tag = tag; victim = vic; force_multi = fm;
    @(negedge clk);
    seen = 0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (cpu_mem_valid) begin seen = 1; break; end
      @(posedge clk); #1;
      victim = 2'($urandom);
    end
    chk("done_seen", 32'(seen), 32'(1));
    if (!e.miss) chk("latency", 32'(k), 32'(e.err ? 2 : 1));
    @(posedge clk); #1;
    cpu_read = 0; cpu_write = 0; force_multi = 0;
    @(negedge clk);
    chk("array_valid", 32'(env_valid), 32'(m_valid));
    chk("array_dirty", 32'(env_dirty), 32'(m_dirty));
    if (e.miss) chk("array_tag", 32'(env_tag[w]), 32'(m_tag[w]));
  endtask

  function automatic logic any_out();
    return |{cpu_mem_valid, lru_load, lru_way, mem_read, mem_write, load_data_line,
             load_data_bytes, load_tag, data_in_select, set_valid, write_valid,
             set_dirty, write_dirty, error};
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    rst = 1; cpu_read = 1; cpu_write = 0; ca_resp = 0; victim = 0;
    cur_tag = 0; force_multi = 0;
    env_valid = 0; env_dirty = 0; m_valid = 0; m_dirty = 0;
    for (int i = 0; i < 4; i++) begin env_tag[i] = 4'he; m_tag[i] = 4'he; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(any_out()), 32'(0));
    @(posedge clk); #1;
    rst = 0; cpu_read = 0;
    @(negedge clk);
    chk("idle_outputs", 32'(any_out()), 32'(0));
    mon_en = 1; arb_en = 1;

    issue(0, 4'd1, 2'd3, 0);
    issue(0, 4'd2, 2'd3, 0);
    issue(0, 4'd3, 2'd3, 0);
    issue(0, 4'd4, 2'd3, 0);
    issue(1, 4'd2, 2'd3, 0);
    issue(0, 4'd3, 2'd0, 0);
    issue(1, 4'd4, 2'd0, 0);
    issue(1, 4'd6, 2'd3, 0);
    issue(0, 4'd5, 2'd3, 0);
    issue(0, 4'd1, 2'd0, 1);

    for (int n = 0; n < 150; n++)
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 2'($urandom),
            ($urandom_range(0, 9) == 0));

    // Reset taken while waiting for write-back completion.
    issue(1, m_tag[0], 2'd0, 0);
    mon_en = 0; arb_en = 0;
    @(posedge clk); #1;
    cpu_read = 1; cur_tag = 4'd15; victim = 2'd0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_write) begin seen = 1; break; end
    end
    chk("rst_wb_reached", 32'(seen), 32'(1));
    @(posedge clk); #1; ca_resp = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_wb_done", 32'(mem_write), 32'(1));
    @(posedge clk); #1; rst = 1; ca_resp = 0;
    @(negedge clk);
    chk("rst_mid_outputs", 32'(any_out()), 32'(0));
    @(posedge clk); #1; rst = 0; cpu_read = 0;
    @(negedge clk);
    chk("post_rst_outputs", 32'(any_out()), 32'(0));
    mon_en = 1; arb_en = 1;
    issue(0, m_tag[1], 2'd0, 0);

`ifdef CACHE_CTRL_TIMEOUT_EN
    mon_en = 0; arb_en = 0;
    @(posedge clk); #1;
    cpu_read = 1; cur_tag = 4'd15; victim = 2'd1;
    cnt = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (error) begin seen = 1; break; end
      if (mem_read || mem_write) cnt++;
    end
    chk("tmo_error", 32'(seen), 32'(1));
    chk("tmo_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_release", 32'(cpu_mem_valid), 32'(1));
    chk("tmo_mem_drop", 32'(mem_read | mem_write), 32'(0));
    @(posedge clk); #1; cpu_read = 0;
    @(negedge clk);
    chk("tmo_idle", 32'(any_out()), 32'(0));
`else
    cnt = 0;
`endif

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
